ex_stage: RTL

- Execute stage of the 5-stage MIPS pipeline. Sits directly downstream of the ID/EX pipeline register and upstream of the EX/MEM register.
- Contains ALU control, ALU, operand forwarding and write-register select.
- Contains an iterative signed multiplier with HI/LO registers (mult/mfhi/mflo).
- Stalls the front of the pipeline while a multiply is in flight.

---
 rtl/mips_ex_pkg.sv | 81 ++++++++
 rtl/mult_iter.sv | 94 +++++++++
 rtl/ex_stage.sv | 104 ++++++++++
 3 files changed

// File: rtl/mips_ex_pkg.sv
// Shared encodings, ALU control decode and forwarding mux for the MIPS execute stage.
// Pure package: no latency, no flow control.
package mips_ex_pkg;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;
    localparam logic [1:0] ALU_OP_SLT   = 2'b11;

    localparam logic [5:0] FUNCT_ADD  = 6'b100000;
    localparam logic [5:0] FUNCT_SUB  = 6'b100010;
    localparam logic [5:0] FUNCT_AND  = 6'b100100;
    localparam logic [5:0] FUNCT_OR   = 6'b100101;
    localparam logic [5:0] FUNCT_SLT  = 6'b101010;
    localparam logic [5:0] FUNCT_MULT = 6'b011000;
    localparam logic [5:0] FUNCT_MFHI = 6'b010000;
    localparam logic [5:0] FUNCT_MFLO = 6'b010010;

    typedef enum logic [2:0] {
        ALU_CTL_ADD,
        ALU_CTL_SUB,
        ALU_CTL_AND,
        ALU_CTL_OR,
        ALU_CTL_SLT,
        ALU_CTL_MULT,
        ALU_CTL_MFHI,
        ALU_CTL_MFLO
    } alu_ctl_e;

    typedef enum logic [1:0] {
        MUL_IDLE,
        MUL_BUSY,
        MUL_DONE
    } mul_state_e;

    function automatic alu_ctl_e decode_alu_ctl(input logic [1:0] alu_op, input logic [5:0] funct);
        alu_ctl_e ctl;
        ctl = ALU_CTL_ADD;
        case (alu_op)
            ALU_OP_ADD: ctl = ALU_CTL_ADD;
            ALU_OP_SUB: ctl = ALU_CTL_SUB;
            ALU_OP_SLT: ctl = ALU_CTL_SLT;
            default: begin
                case (funct)
                    FUNCT_ADD:  ctl = ALU_CTL_ADD;
                    FUNCT_SUB:  ctl = ALU_CTL_SUB;
                    FUNCT_AND:  ctl = ALU_CTL_AND;
                    FUNCT_OR:   ctl = ALU_CTL_OR;
                    FUNCT_SLT:  ctl = ALU_CTL_SLT;
                    FUNCT_MULT: ctl = ALU_CTL_MULT;
                    FUNCT_MFHI: ctl = ALU_CTL_MFHI;
                    FUNCT_MFLO: ctl = ALU_CTL_MFLO;
                    default:    ctl = ALU_CTL_ADD;
                endcase
            end
        endcase
        return ctl;
    endfunction

    // EX/MEM has priority over MEM/WB; register 0 is hard-wired and never forwarded.
    function automatic logic [31:0] fwd_sel(
        input logic [4:0]  src,
        input logic [31:0] id_val,
        input logic        exm_we,
        input logic [4:0]  exm_rd,
        input logic [31:0] exm_val,
        input logic        wb_we,
        input logic [4:0]  wb_rd,
        input logic [31:0] wb_val
    );
        logic [31:0] val;
        val = id_val;
        if (src != 5'd0 && exm_we && exm_rd == src) begin
            val = exm_val;
        end else if (src != 5'd0 && wb_we && wb_rd == src) begin
            val = wb_val;
        end
        return val;
    endfunction

endpackage

// File: rtl/mult_iter.sv
// Iterative signed 32x32 multiplier with HI/LO, retiring MUL_BITS_PER_CYC multiplier bits per cycle.
// Latency: 1 launch cycle + 32/MUL_BITS_PER_CYC iterations, then a one-cycle DONE hand-off.
// Backpressure: stall is high from the launch cycle until DONE; DONE never relaunches.
module mult_iter
    import mips_ex_pkg::*;
#(
    parameter int MUL_BITS_PER_CYC = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        stall
);

    localparam int K  = MUL_BITS_PER_CYC;
    localparam int N  = 32 / K;
    localparam int CW = 5;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    mul_state_e    state;
    logic [CW-1:0] count;
    logic [63:0]   mcand;
    logic [31:0]   mplier;
    logic [63:0]   acc;
    logic [63:0]   term;
    logic          stall_q;
    logic          launch;

    assign launch = (state == MUL_IDLE) && start;
    // The launch cycle must stall before any register has seen the mult; reset overrides.
    assign stall  = stall_q | (launch & reset);

    // The multiplier's top bit carries negative weight in two's complement.
    always_comb begin
        term = '0;
        for (int j = 0; j < K; j++) begin
            if (mplier[j]) begin
                if (count == LAST && j == K - 1) begin
                    term = term - (mcand << j);
                end else begin
                    term = term + (mcand << j);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= MUL_IDLE;
            count   <= '0;
            stall_q <= 1'b0;
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            case (state)
                MUL_IDLE: begin
                    if (start) begin
                        mcand   <= {{32{op_a[31]}}, op_a};
                        mplier  <= op_b;
                        acc     <= '0;
                        count   <= '0;
                        stall_q <= 1'b1;
                        state   <= MUL_BUSY;
                    end
                end
                MUL_BUSY: begin
                    acc    <= acc + term;
                    mcand  <= mcand << K;
                    mplier <= mplier >> K;
                    count  <= count + CW'(1);
                    if (count == LAST) begin
                        {hi, lo} <= acc + term;
                        stall_q  <= 1'b0;
                        state    <= MUL_DONE;
                    end
                end
                MUL_DONE: begin
                    state <= MUL_IDLE;
                end
                default: begin
                    state <= MUL_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: ALU control, ALU, write-register select, operand forwarding (EX_FWD_EN) and mult/mfhi/mflo.
// Latency: datapath is combinational; a mult holds the stage for 32/MUL_BITS_PER_CYC + 1 cycles.
// Backpressure: stall freezes PC, IF/ID and ID/EX while a multiply is in flight.
module ex_stage
    import mips_ex_pkg::*;
#(
    parameter int MUL_BITS_PER_CYC = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        reg_write_in,
    input  logic        mem_to_reg_in,
    input  logic        mem_read_in,
    input  logic        mem_write_in,
    input  logic        alu_src_in,
    input  logic        reg_dst_in,
    input  logic [1:0]  alu_op_in,
    input  logic [31:0] read_data1_in,
    input  logic [31:0] read_data2_in,
    input  logic [31:0] sign_extend_in,
    input  logic [4:0]  rt_in,
    input  logic [4:0]  rd_in,
    input  logic [5:0]  funct_in,
    input  logic        ex_mem_reg_write,
    input  logic        mem_wb_reg_write,
    input  logic [4:0]  ex_mem_rd,
    input  logic [4:0]  mem_wb_rd,
    input  logic [31:0] ex_mem_result,
    input  logic [31:0] mem_wb_result,
    output logic        reg_write_out,
    output logic        mem_to_reg_out,
    output logic        mem_read_out,
    output logic        mem_write_out,
    output logic [31:0] alu_result,
    output logic [31:0] store_data,
    output logic [4:0]  write_reg,
    output logic        zero,
    output logic        stall
);

    alu_ctl_e    alu_ctl;
    logic        is_mult;
    logic [31:0] op_a;
    logic [31:0] fwd_rt;
    logic [31:0] op_b;
    logic [31:0] hi;
    logic [31:0] lo;

    assign alu_ctl = decode_alu_ctl(alu_op_in, funct_in);
    assign is_mult = (alu_ctl == ALU_CTL_MULT);

`ifdef EX_FWD_EN
    // ID/EX does not carry an rs field; rd_in stands in as the operand-A source specifier.
    assign op_a   = fwd_sel(rd_in, read_data1_in, ex_mem_reg_write, ex_mem_rd, ex_mem_result,
                            mem_wb_reg_write, mem_wb_rd, mem_wb_result);
    assign fwd_rt = fwd_sel(rt_in, read_data2_in, ex_mem_reg_write, ex_mem_rd, ex_mem_result,
                            mem_wb_reg_write, mem_wb_rd, mem_wb_result);
`else
    logic unused_fwd;
    assign op_a       = read_data1_in;
    assign fwd_rt     = read_data2_in;
    assign unused_fwd = ^{ex_mem_reg_write, mem_wb_reg_write, ex_mem_rd, mem_wb_rd,
                          ex_mem_result, mem_wb_result};
`endif

    assign op_b = alu_src_in ? sign_extend_in : fwd_rt;

    always_comb begin
        alu_result = '0;
        case (alu_ctl)
            ALU_CTL_ADD:  alu_result = op_a + op_b;
            ALU_CTL_SUB:  alu_result = op_a - op_b;
            ALU_CTL_AND:  alu_result = op_a & op_b;
            ALU_CTL_OR:   alu_result = op_a | op_b;
            ALU_CTL_SLT:  alu_result = {31'd0, $signed(op_a) < $signed(op_b)};
            ALU_CTL_MFHI: alu_result = hi;
            ALU_CTL_MFLO: alu_result = lo;
            default:      alu_result = '0;
        endcase
    end

    assign zero           = (alu_result == 32'd0);
    assign store_data     = fwd_rt;
    assign write_reg      = reg_dst_in ? rd_in : rt_in;
    // A mult writes only HI/LO, never the register file.
    assign reg_write_out  = reg_write_in & ~is_mult;
    assign mem_to_reg_out = mem_to_reg_in;
    assign mem_read_out   = mem_read_in;
    assign mem_write_out  = mem_write_in;

    mult_iter #(
        .MUL_BITS_PER_CYC(MUL_BITS_PER_CYC)
    ) u_mult (
        .clk   (clk),
        .reset (reset),
        .start (is_mult),
        .op_a  (op_a),
        .op_b  (fwd_rt),
        .hi    (hi),
        .lo    (lo),
        .stall (stall)
    );

endmodule
